// File: rtl/apb_slave_regfile_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and status register constants.
// Pairs with apb_slave_regfile; the optional PSLVERR output is controlled by APB_SLV_PSLVERR_EN.
package definesPkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_e;

    localparam int          STATUS_IDX     = 0;
    localparam logic [15:0] STATUS_CNT_MAX = 16'hFFFF;

    // Write counter increment that sticks at the maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == STATUS_CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_reg_bank.sv
// Register storage for apb_slave_regfile: NUM_REGS words plus a read-only status word at index 0.
// Status word = {NUM_REGS[15:0], saturating count of committed writes}.
module apb_reg_bank
    import definesPkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic [APB_DATA_WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0]          i_rd_idx,
    output logic [APB_DATA_WIDTH-1:0] o_rd_data
);

    logic [APB_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [15:0]               r_wr_cnt;
    logic                      w_wr_ok;

    // Index 0 has no writable storage; a write there must neither land nor count.
    assign w_wr_ok = i_wr_en && (i_wr_idx != IDX_W'(STATUS_IDX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_wr_idx] <= i_wr_data;
            r_wr_cnt         <= sat_inc16(r_wr_cnt);
        end
    end

    always_comb begin
        if (i_rd_idx == IDX_W'(STATUS_IDX)) begin
            o_rd_data = {16'(NUM_REGS), r_wr_cnt};
        end else begin
            o_rd_data = r_regs[i_rd_idx];
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer terminating transfers in a local register bank, with WAIT_CYCLES wait states.
// Define APB_SLV_PSLVERR_EN to add PSLVERR for invalid addresses and writes to the status register.
module apb_slave_regfile
    import definesPkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      apbClk,
    input  logic                      rst,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PREADY,
`ifdef APB_SLV_PSLVERR_EN
    output logic                      PSLVERR,
`endif
    output apb_slv_state_e            o_dbg_state
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Handshake: a transfer is a setup cycle (PSEL & !PENABLE) followed by access cycles
    // (PSEL & PENABLE); it completes in the single cycle PREADY is high, and dropping
    // PSEL or PENABLE while PREADY is low abandons it with no side effects.
    apb_slv_state_e            r_state;
    apb_slv_state_e            w_next_state;
    logic [3:0]                r_wait_cnt;
    logic [3:0]                w_next_wait_cnt;
    logic                      r_pready;
    logic [APB_DATA_WIDTH-1:0] r_prdata;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic                      r_write;
    logic [APB_DATA_WIDTH-1:0] r_wdata;

    logic                      w_capture;
    logic                      w_done;
    logic [APB_ADDR_WIDTH-1:0] w_op_addr;
    logic                      w_op_write;
    logic [APB_DATA_WIDTH-1:0] w_op_wdata;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_valid;
    logic                      w_wr_en;
    logic                      w_rd_commit;
    logic [APB_DATA_WIDTH-1:0] w_bank_rd;
    logic [APB_DATA_WIDTH-1:0] w_rd_value;

    // A new setup phase is accepted when idle or in the completion cycle of the previous transfer.
    assign w_capture = ((r_state == IDLE) || r_pready) && PSEL && !PENABLE;

    // With no wait states the transfer completes off the setup-phase values, before they are latched.
    assign w_op_addr  = w_capture ? PADDR  : r_addr;
    assign w_op_write = w_capture ? PWRITE : r_write;
    assign w_op_wdata = w_capture ? PWDATA : r_wdata;

    assign w_idx   = w_op_addr[IDX_W+1:2];
    assign w_valid = (w_op_addr[1:0] == 2'b00) &&
                     (w_op_addr < APB_ADDR_WIDTH'(NUM_REGS * 4));

    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_done          = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = IDLE;
            end
            SETUP, ACCESS: begin
                if (r_pready) begin
                    w_next_state = IDLE;
                end else if (!(PSEL && PENABLE)) begin
                    w_next_state    = IDLE;
                    w_next_wait_cnt = 4'd0;
                end else begin
                    w_next_state    = ACCESS;
                    w_next_wait_cnt = r_wait_cnt - 4'd1;
                    w_done          = (r_wait_cnt == 4'd1);
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_next_wait_cnt = 4'd0;
            end
        endcase
        if (w_capture) begin
            w_next_state    = SETUP;
            w_next_wait_cnt = 4'(WAIT_CYCLES);
            w_done          = (WAIT_CYCLES == 0);
        end
    end

    always_ff @(posedge apbClk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            r_pready   <= w_done;
            if (w_capture) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
            end
            if (w_rd_commit) begin
                r_prdata <= w_rd_value;
            end
        end
    end

    assign w_wr_en    = w_done && w_op_write && w_valid &&
                        (w_idx != IDX_W'(STATUS_IDX));
    assign w_rd_value = w_valid ? w_bank_rd : '0;

`ifdef APB_SLV_PSLVERR_EN
    logic r_pslverr;
    logic w_err;

    // Erroring reads leave PRDATA untouched so they change no state at all.
    assign w_err       = !w_valid || (w_op_write && (w_idx == IDX_W'(STATUS_IDX)));
    assign w_rd_commit = w_done && !w_op_write && w_valid;

    always_ff @(posedge apbClk or negedge rst) begin
        if (!rst) begin
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_done && w_err;
        end
    end

    assign PSLVERR = r_pslverr;
`else
    assign w_rd_commit = w_done && !w_op_write;
`endif

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_bank (
        .i_clk     (apbClk),
        .i_rst_n   (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_idx),
        .i_wr_data (w_op_wdata),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_bank_rd)
    );

    assign PRDATA      = r_prdata;
    assign PREADY      = r_pready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances (WAIT_CYCLES 0, 3, 2) on a shared bus
// with per-instance PSEL; expected values are hand-computed constants.
module tb_apb_slave_regfile;
    import definesPkg::*;

    logic        apbClk = 1'b0;
    logic        rst;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    apb_slv_state_e st   [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 apbClk = ~apbClk;

    // ---------------- DUTs: index 0 -> WAIT 0, 1 -> WAIT 3, 2 -> WAIT 2 ----------------
    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .apbClk(apbClk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
`ifdef APB_SLV_PSLVERR_EN
        .PSLVERR(pslverr[0]),
`endif
        .o_dbg_state(st[0])
    );

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3)) u_dut_w3 (
        .apbClk(apbClk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
`ifdef APB_SLV_PSLVERR_EN
        .PSLVERR(pslverr[1]),
`endif
        .o_dbg_state(st[1])
    );

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2)) u_dut_w2 (
        .apbClk(apbClk), .rst(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
`ifdef APB_SLV_PSLVERR_EN
        .PSLVERR(pslverr[2]),
`endif
        .o_dbg_state(st[2])
    );

`ifndef APB_SLV_PSLVERR_EN
    assign pslverr[0] = 1'b0;
    assign pslverr[1] = 1'b0;
    assign pslverr[2] = 1'b0;
`endif

    // ---------------- driver ----------------
    // One complete transfer; waits = access cycles seen with PREADY low before completion.
    task automatic apb_xfer(input int sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int waits, output logic err);
        int n;
        n = 0;
        @(negedge apbClk);
        psel      = 3'b000;
        psel[sel] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wdata;
        @(negedge apbClk);
        penable = 1'b1;
        while (pready[sel] !== 1'b1 && n < 20) begin
            n++;
            @(negedge apbClk);
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout dut=%0d addr=%h: PREADY never rose within 20 cycles", sel, addr);
        end
        waits   = n;
        rdata   = prdata[sel];
        err     = pslverr[sel];
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        int          w;
        logic        e;
        rst     = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(negedge apbClk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (pready[i] !== 1'b0 || prdata[i] !== 32'h0 || st[i] !== IDLE) begin
                n_fail++;
                $display("FAIL reset_outputs dut=%0d: got PREADY=%b PRDATA=%h state=%0d, want 0/0/IDLE",
                         i, pready[i], prdata[i], st[i]);
            end
        end
        rst = 1'b1;
        // PENABLE high while idle must not start a transfer.
        psel[0] = 1'b1;
        penable = 1'b1;
        repeat (3) @(negedge apbClk);
        n_tests++;
        if (st[0] !== IDLE || pready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL penable_in_idle: got state=%0d PREADY=%b, want IDLE/0", st[0], pready[0]);
        end
        psel    = 3'b000;
        penable = 1'b0;
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0000) begin
            n_fail++;
            $display("FAIL reset_status: got %h, want 00100000", rd);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] rd;
        int          w;
        logic        e;
        apb_xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, rd, w, e);
        n_tests++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL wait0_latency: got %0d wait cycles, want 0", w);
        end
`ifdef APB_SLV_PSLVERR_EN
        n_tests++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_pslverr: got %b, want 0", e);
        end
`endif
        @(negedge apbClk);
        n_tests++;
        if (pready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pready_one_cycle: got PREADY=%b after completion, want 0", pready[0]);
        end
        apb_xfer(0, 1'b0, 32'h4, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wait0_readback: got %h, want deadbeef", rd);
        end
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0001) begin
            n_fail++;
            $display("FAIL wait0_status: got %h, want 00100001", rd);
        end
    endtask

    task automatic test_wait3();
        logic [31:0] rd;
        int          w;
        logic        e;
        apb_xfer(1, 1'b1, 32'h3C, 32'h1234_5678, rd, w, e);
        n_tests++;
        if (w !== 3) begin
            n_fail++;
            $display("FAIL wait3_write_latency: got %0d wait cycles, want 3", w);
        end
        apb_xfer(1, 1'b0, 32'h3C, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h1234_5678 || w !== 3) begin
            n_fail++;
            $display("FAIL wait3_readback: got %h after %0d waits, want 12345678 after 3", rd, w);
        end
    endtask

    task automatic test_invalid();
        logic [31:0] rd;
        int          w;
        logic        e;
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'h40;
        bad_addr[1] = 32'h6;
        bad_addr[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(0, 1'b1, bad_addr[i], 32'hFFFF_FFFF, rd, w, e);
`ifdef APB_SLV_PSLVERR_EN
            n_tests++;
            if (e !== 1'b1) begin
                n_fail++;
                $display("FAIL invalid_pslverr addr=%h: got %b, want 1", bad_addr[i], e);
            end
`endif
        end
        apb_xfer(0, 1'b0, 32'h4, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL invalid_reg1_intact: got %h, want deadbeef", rd);
        end
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0001) begin
            n_fail++;
            $display("FAIL invalid_count_intact: got %h, want 00100001", rd);
        end
        apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, w, e);
`ifdef APB_SLV_PSLVERR_EN
        n_tests++;
        if (e !== 1'b1 || rd !== 32'h0010_0001) begin
            n_fail++;
            $display("FAIL invalid_read: got err=%b PRDATA=%h, want 1/00100001", e, rd);
        end
`else
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL invalid_read: got %h, want 0", rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp;
        int          w;
        logic        e;
        logic [31:0] addrs [4];
        logic [31:0] vals  [4];
        addrs[0] = 32'h08; vals[0] = 32'h0000_0002;
        addrs[1] = 32'h0C; vals[1] = 32'hCAFE_F00D;
        addrs[2] = 32'h10; vals[2] = 32'h8000_0001;
        addrs[3] = 32'h3C; vals[3] = 32'h5A5A_0F0F;
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b1, addrs[i], vals[i], rd, w, e);
            exp_q.push_back(vals[i]);
        end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b0, addrs[i], 32'h0, rd, w, e);
            exp = exp_q.pop_front();
            n_tests++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL b2b_read addr=%h: got %h, want %h", addrs[i], rd, exp);
            end
        end
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0005) begin
            n_fail++;
            $display("FAIL b2b_status: got %h, want 00100005", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int          w;
        logic        e;
        logic        saw_ready;
        apb_xfer(2, 1'b1, 32'hC, 32'h0BAD_F00D, rd, w, e);
        n_tests++;
        if (w !== 2) begin
            n_fail++;
            $display("FAIL wait2_latency: got %0d wait cycles, want 2", w);
        end
        // Write to 0x8 abandoned after one access cycle.
        saw_ready = 1'b0;
        @(negedge apbClk);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'hA5A5_A5A5;
        @(negedge apbClk);
        penable = 1'b1;
        saw_ready = saw_ready | pready[2];
        @(negedge apbClk);
        penable = 1'b0;
        saw_ready = saw_ready | pready[2];
        @(negedge apbClk);
        psel = 3'b000;
        n_tests++;
        if (st[2] !== IDLE) begin
            n_fail++;
            $display("FAIL abort_state: got %0d, want IDLE", st[2]);
        end
        repeat (6) begin
            saw_ready = saw_ready | pready[2];
            @(negedge apbClk);
        end
        n_tests++;
        if (saw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_pready: got PREADY high, want it to stay 0");
        end
        apb_xfer(2, 1'b0, 32'h8, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reg2: got %h, want 0", rd);
        end
        apb_xfer(2, 1'b0, 32'hC, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL abort_reg3: got %h, want 0badf00d", rd);
        end
        apb_xfer(2, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0001) begin
            n_fail++;
            $display("FAIL abort_status: got %h, want 00100001", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          w;
        logic        e;
        @(negedge apbClk);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'hC;
        @(negedge apbClk);
        penable = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (pready[2] !== 1'b0 || prdata[2] !== 32'h0 || st[2] !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got PREADY=%b PRDATA=%h state=%0d, want 0/0/IDLE",
                     pready[2], prdata[2], st[2]);
        end
        @(negedge apbClk);
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge apbClk);
        rst = 1'b1;
        apb_xfer(2, 1'b0, 32'hC, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_reg3: got %h, want 0", rd);
        end
        apb_xfer(2, 1'b0, 32'h0, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0010_0000) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h, want 00100000", rd);
        end
        apb_xfer(1, 1'b0, 32'h3C, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_w3_reg15: got %h, want 0", rd);
        end
        apb_xfer(0, 1'b0, 32'h4, 32'h0, rd, w, e);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_w0_reg1: got %h, want 0", rd);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        test_reset();
        test_wait0();
        test_wait3();
        test_invalid();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer that consumes the transfers issued by the team's APB master BFM/driver and terminates them in a local register bank.
- Decodes PADDR, inserts a programmable number of wait states via PREADY, and performs writes and reads on NUM_REGS 32-bit registers.
- Register 0 is a read-only status register counting completed writes. It serves as the DUT-side endpoint for APB bench bring-up and as the register front-end for future peripherals.

Parameters:
- NUM_REGS, 16, number of word registers (power of two, 2..256); register 0 is the status register.
- WAIT_CYCLES, 0, wait states inserted in the access phase before PREADY rises (0..15). Default 0 keeps it compatible with drivers that hold PENABLE for one cycle.
- Address width APB_ADDR_WIDTH and data width APB_DATA_WIDTH come from definesPkg (32/32).

Ports:
- apbClk  input  1  APB clock; all logic on the rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  APB_ADDR_WIDTH  byte address; word-aligned.
- PWDATA  input  APB_DATA_WIDTH  write data.
- PRDATA  output  APB_DATA_WIDTH  read data, registered.
- PREADY  output  1  transfer completion, registered.

Behaviour:
- Reset (rst low, async): FSM=IDLE; PREADY=0; PRDATA=0; all registers=0; wait counter=0; write counter=0.
- FSM states and transitions:
  - IDLE: PSEL & !PENABLE goes to SETUP.
  - SETUP: loads the wait counter with WAIT_CYCLES and latches PADDR/PWRITE/PWDATA. Next cycle, PSEL & PENABLE goes to ACCESS; otherwise IDLE.
  - ACCESS: while the counter is non-zero, it decrements and PREADY stays 0. When the counter reaches 0, PREADY=1 for exactly one cycle, the operation commits on that edge, and the FSM returns to IDLE (or SETUP if a new PSEL & !PENABLE is seen).
- Latency: the PREADY high cycle is the (WAIT_CYCLES+1)th access-phase cycle.
- Decode: idx = PADDR[log2(NUM_REGS)+1:2]. Valid when PADDR[1:0]==0 and PADDR < NUM_REGS*4.
- Write commit, valid idx != 0: reg[idx] <= latched PWDATA.
- Writes to idx 0: ignored.
- Invalid-address write: ignored and no counter increment.
- Status register 0: bits[15:0] = count of committed valid writes, saturating at 0xFFFF; bits[31:16] = NUM_REGS.
- Read commit: PRDATA <= reg[idx] (invalid address gives 0). PRDATA holds its value until the next read commit, so late-sampling masters read stable data.
- Protocol violations:
  - PSEL or PENABLE deasserting during ACCESS before PREADY aborts to IDLE with no commit and PREADY=0.
  - PENABLE high in IDLE is ignored.
- Simultaneous write to idx k and a status-counter update: both take effect, since they target different storage.
- Reset asserted mid-transfer: immediate clear; the transfer is lost.

Optional Feature:
- Macro: APB_SLV_PSLVERR_EN.
- With the macro defined:
  - Adds output port PSLVERR (1 bit), reset 0.
  - PSLVERR is asserted in the same cycle as PREADY, only for an invalid address or a write to register 0.
  - Such transfers never modify state.
- Without the macro: no PSLVERR port; those transfers complete silently as described in Behaviour.

Decomposition:
- definesPkg (shared package) gains:
  - typedef enum apb_slv_state_e {IDLE, SETUP, ACCESS}.
  - STATUS_IDX = 0.
  - STATUS_CNT_MAX = 16'hFFFF.
- apb_slave_regfile keeps the FSM, decode and wait counter.
- Sub-module apb_reg_bank: NUM_REGS x 32 storage with write enable, index and read port. It also holds the status counter and async-reset clear.

Test Plan:
- Reset, then read 0x0 -> PRDATA = 0x0010_0000 (NUM_REGS=16 in bits[31:16], write count 0); PREADY low during reset.
- WAIT_CYCLES=0: write 0x4 = 0xDEADBEEF, then read 0x4 -> PREADY high on the first access cycle; PRDATA = 0xDEADBEEF; status reads 0x0010_0001.
- WAIT_CYCLES=3: write 0x3C = 0x1234_5678 -> PREADY low for 3 access cycles and high on the 4th. Readback gives 0x1234_5678.
- Write 0x40 (out of range) and 0x6 (misaligned) with 0xFFFF_FFFF -> no register changes and write count unchanged. With APB_SLV_PSLVERR_EN, PSLVERR=1 with PREADY on both.
- WAIT_CYCLES=2: drop PENABLE after 1 access cycle of a write to 0x8 = 0xA5A5_A5A5 -> no PREADY and reg 2 stays 0. Then assert rst low mid-read -> PREADY=0, PRDATA=0, all registers 0 immediately.
